jzjpcc_memory_stage: RTL and testbench
======================================

// Module: jzjpcc_memory_stage
// PURPOSE
//  Memory stage of the jzjpcc pipeline: the consumer of the execute->memory pipeline register.
//  Takes the registered ALU result / store data / byte mask and performs the load/store over a
//  variable-latency req/ack data-memory port. Stalls upstream while the access is outstanding.
//  Extends load data and registers everything into the memory->writeback pipeline register.
// PARAMETERS
//  MEM_ADDR_W      30   word-address width to data memory (byte address bits [31:2])
//  TIMEOUT_CYCLES  16   max WAIT cycles before the access is aborted as a bus error (>=1)
// PORTS
//  clock             in   1   single clock, rising edge
//  reset             in   1   synchronous, active-high
//  inValid           in   1   execute->memory register holds a real instruction (0 = bubble)
//  inAluResult       in   32  byte address (loads/stores) or ALU result (others)
//  inRdAddr          in   5   destination register
//  inRdSource        in   2   rd_source_t: ALU / MEM / PC+4 / IMM
//  inRdWriteEnable   in   1   instruction writes rd
//  inMemReadEnable   in   1   load
//  inMemWriteEnable  in   1   store
//  inLoadFunct3      in   3   LB=000 LH=001 LW=010 LBU=100 LHU=101
//  inMemDataToWrite  in   32  store data, pre-shifted into lanes
//  inMemByteMask     in   4   store byte-lane enables
//  stall             out  1   comb.; hold execute->memory register and everything upstream
//  memReq            out  1   data-memory request
//  memWriteEnable    out  1   request is a store
//  memAddr           out  MEM_ADDR_W  word address = inAluResult[31:2]
//  memWriteData      out  32  = inMemDataToWrite
//  memByteMask       out  4   = inMemByteMask (stores), 4'hF (loads)
//  memAck            in   1   request completes this cycle; memReadData valid when load
//  memReadData       in   32  raw word from memory
//  wbValid, wbRdAddr, wbRdSource, wbRdWriteEnable, wbAluResult[32], wbMemData[32],
//  wbMisaligned, wbBusError   out   memory->writeback pipeline register
// BEHAVIOUR
//  - access = inValid & (inMemReadEnable | inMemWriteEnable). If both enables are high, the store
//    wins and the load is ignored; rd handling still passes through.
//  - memReq = access & (state==IDLE | state==WAIT). Comb. from inputs; zero-wait ack allowed.
//  - stall = access & ~memAck & ~timeout. Address, data and mask stay stable while stalled.
//  - FSM: IDLE -> WAIT when access & ~memAck. WAIT -> IDLE on memAck or timeout.
//    IDLE stays IDLE otherwise. A WAIT counter clears on entry to WAIT.
//    timeout = (state==WAIT) & (count==TIMEOUT_CYCLES-1) & ~memAck.
//  - Writeback register loads every cycle:
//    - complete = inValid & (~access | memAck | timeout).
//    - wbValid <= complete. When not complete, a bubble: wbValid=0, wbRdWriteEnable=0.
//    - On complete: rd fields and inAluResult pass through; wbMemData <= extended load.
//    - wbBusError <= timeout. On timeout, wbRdWriteEnable is forced 0.
//  - Latency: non-memory op 1 cycle; memory op 1 + wait cycles. Back-to-back accesses need no idle cycle.
//  - Load extension, off = inAluResult[1:0]:
//    - LB/LBU: byte (memReadData >> 8*off) sign/zero extended.
//    - LH/LHU: half at off[1], sign/zero extended.
//    - LW: word.
//    - Misaligned (LH/LHU with off[0]=1; LW with off!=0): the access proceeds at the aligned
//      word, and wbMisaligned=1 for that instruction.
//  - Reset: state=IDLE, count=0, all wb* outputs 0. memReq is low in the reset cycle.
//    A reset during WAIT abandons the request; memory must tolerate an unacked drop.
//  - memAck while memReq=0 is ignored.
// STRUCTURE
//  - jzjpcc_pkg: rd_source_t enum; LOAD_* funct3 constants; mem_state_t {IDLE, WAIT}.
//  - Sub-module jzjpcc_load_extender (comb.: word, funct3, offset -> data, misaligned).
//  - FSM, counter and wb register live in this module.
// TESTING
//  1. ALU op, inAluResult=0x1234, rd=5 -> next cycle wbValid=1, wbAluResult=0x1234, no memReq.
//  2. SW addr 0x100, mask 4'hF, ack same cycle -> memAddr=0x40, memWriteEnable=1, stall never high.
//  3. LB addr 0x103, memReadData=0x80xxxxxx, ack after 3 cycles -> stall 3 cycles,
//     3 bubbles, then wbMemData=0xFFFFFF80; LBU gives 0x00000080.
//  4. LH addr 0x101 -> wbMisaligned=1; LHU addr 0x102, word 0xBEEF0000 -> wbMemData=0x0000BEEF.
//  5. Load, memAck never -> after 16 WAIT cycles: wbBusError=1, wbRdWriteEnable=0, stall drops.
//  6. reset asserted mid-WAIT -> next cycle memReq=0, wbValid=0, state IDLE; next load completes normally.

Source files
------------

// File: rtl/jzjpcc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_pkg
// Brief    : Shared types and constants for the jzjpcc memory stage.
// Revision : 1.0
// ============================================================================
package jzjpcc_pkg;

    typedef enum logic [1:0] {
        RD_SRC_ALU = 2'd0,
        RD_SRC_MEM = 2'd1,
        RD_SRC_PC4 = 2'd2,
        RD_SRC_IMM = 2'd3
    } rd_source_t;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/jzjpcc_load_extender.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_load_extender
// Brief    : Selects and sign/zero extends load data from a raw memory word.
// Revision : 1.0
// ============================================================================
module jzjpcc_load_extender
    import jzjpcc_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data,
    output logic        misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0: w_byte = word[7:0];
            2'd1: w_byte = word[15:8];
            2'd2: w_byte = word[23:16];
            2'd3: w_byte = word[31:24];
            default: w_byte = word[7:0];
        endcase
        // Misaligned halves still use the half selected by offset[1].
        w_half = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            LOAD_LB:  data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: data = {24'd0, w_byte};
            LOAD_LH: begin
                data       = {{16{w_half[15]}}, w_half};
                misaligned = offset[0];
            end
            LOAD_LHU: begin
                data       = {16'd0, w_half};
                misaligned = offset[0];
            end
            LOAD_LW: begin
                data       = word;
                misaligned = |offset;
            end
            default: data = word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/jzjpcc_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : jzjpcc_memory_stage
// Brief    : Memory pipeline stage: req/ack data access, stall, load extension
//            and the memory->writeback pipeline register.
// Revision : 1.0
// ============================================================================
module jzjpcc_memory_stage
    import jzjpcc_pkg::*;
#(
    parameter int MEM_ADDR_W     = 30,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inValid,
    input  logic [31:0]           inAluResult,
    input  logic [4:0]            inRdAddr,
    input  rd_source_t            inRdSource,
    input  logic                  inRdWriteEnable,
    input  logic                  inMemReadEnable,
    input  logic                  inMemWriteEnable,
    input  logic [2:0]            inLoadFunct3,
    input  logic [31:0]           inMemDataToWrite,
    input  logic [3:0]            inMemByteMask,
    output logic                  stall,
    output logic                  memReq,
    output logic                  memWriteEnable,
    output logic [MEM_ADDR_W-1:0] memAddr,
    output logic [31:0]           memWriteData,
    output logic [3:0]            memByteMask,
    input  logic                  memAck,
    input  logic [31:0]           memReadData,
    output logic                  wbValid,
    output logic [4:0]            wbRdAddr,
    output rd_source_t            wbRdSource,
    output logic                  wbRdWriteEnable,
    output logic [31:0]           wbAluResult,
    output logic [31:0]           wbMemData,
    output logic                  wbMisaligned,
    output logic                  wbBusError
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic              w_access;
    logic              w_is_load;
    logic              w_ack;
    logic              w_timeout;
    logic              w_complete;
    logic [31:0]       w_ext_data;
    logic              w_ext_misaligned;

    assign w_access  = inValid & (inMemReadEnable | inMemWriteEnable);
    // A store wins when both enables are set.
    assign w_is_load = inMemReadEnable & ~inMemWriteEnable;

    assign memReq         = w_access & ~reset & ((r_state == IDLE) | (r_state == WAIT));
    assign memWriteEnable = w_access & inMemWriteEnable;
    assign memAddr        = inAluResult[MEM_ADDR_W+1:2];
    assign memWriteData   = inMemDataToWrite;
    assign memByteMask    = inMemWriteEnable ? inMemByteMask : 4'hF;

    // An ack that arrives without a request is ignored.
    assign w_ack      = memAck & memReq;
    assign w_timeout  = (r_state == WAIT) & (r_count == CNT_W'(TIMEOUT_CYCLES - 1)) & ~w_ack;
    assign stall      = w_access & ~w_ack & ~w_timeout;
    assign w_complete = inValid & (~w_access | w_ack | w_timeout);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_access & ~w_ack) w_state_next = WAIT;
            WAIT:    if (w_ack | w_timeout) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Held at zero in IDLE so it is clear on every entry to WAIT.
    always_ff @(posedge clock) begin
        if (reset || r_state == IDLE) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    jzjpcc_load_extender u_load_extender (
        .word       (memReadData),
        .funct3     (inLoadFunct3),
        .offset     (inAluResult[1:0]),
        .data       (w_ext_data),
        .misaligned (w_ext_misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wbValid         <= 1'b0;
            wbRdAddr        <= '0;
            wbRdSource      <= RD_SRC_ALU;
            wbRdWriteEnable <= 1'b0;
            wbAluResult     <= '0;
            wbMemData       <= '0;
            wbMisaligned    <= 1'b0;
            wbBusError      <= 1'b0;
        end else begin
            wbValid         <= w_complete;
            wbRdAddr        <= inRdAddr;
            wbRdSource      <= inRdSource;
            wbRdWriteEnable <= w_complete & inRdWriteEnable & ~w_timeout;
            wbAluResult     <= inAluResult;
            wbMemData       <= w_is_load ? w_ext_data : 32'd0;
            wbMisaligned    <= w_complete & w_access & w_is_load & w_ext_misaligned;
            wbBusError      <= w_complete & w_timeout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_memory_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_jzjpcc_memory_stage
// Brief    : Self-checking bench: directed and random memory-stage operations
//            against a behavioural reference model.
// Revision : 1.0
// ============================================================================
module tb_jzjpcc_memory_stage;
    import jzjpcc_pkg::*;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid, inRdWriteEnable, inMemReadEnable, inMemWriteEnable;
    logic [31:0] inAluResult, inMemDataToWrite, memReadData;
    logic [4:0]  inRdAddr;
    rd_source_t  inRdSource;
    logic [2:0]  inLoadFunct3;
    logic [3:0]  inMemByteMask;
    logic        stall, memReq, memWriteEnable, memAck;
    logic [29:0] memAddr;
    logic [31:0] memWriteData;
    logic [3:0]  memByteMask;
    logic        wbValid, wbRdWriteEnable, wbMisaligned, wbBusError;
    logic [4:0]  wbRdAddr;
    rd_source_t  wbRdSource;
    logic [31:0] wbAluResult, wbMemData;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    jzjpcc_memory_stage #(.MEM_ADDR_W(30), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inAluResult(inAluResult),
        .inRdAddr(inRdAddr), .inRdSource(inRdSource), .inRdWriteEnable(inRdWriteEnable),
        .inMemReadEnable(inMemReadEnable), .inMemWriteEnable(inMemWriteEnable),
        .inLoadFunct3(inLoadFunct3), .inMemDataToWrite(inMemDataToWrite),
        .inMemByteMask(inMemByteMask), .stall(stall), .memReq(memReq),
        .memWriteEnable(memWriteEnable), .memAddr(memAddr), .memWriteData(memWriteData),
        .memByteMask(memByteMask), .memAck(memAck), .memReadData(memReadData),
        .wbValid(wbValid), .wbRdAddr(wbRdAddr), .wbRdSource(wbRdSource),
        .wbRdWriteEnable(wbRdWriteEnable), .wbAluResult(wbAluResult), .wbMemData(wbMemData),
        .wbMisaligned(wbMisaligned), .wbBusError(wbBusError)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load result from plain arithmetic on the raw word.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input int off);
        logic [31:0] b, h;
        b = (word >> (8 * off)) & 32'hFF;
        h = (word >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
        return ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) || (f3 == 3'd2 && off != 0);
    endfunction

    // Drives one instruction and checks it cycle by cycle; lat = cycles before
    // ack (0 = same cycle), negative = never acked.
    task automatic op(input logic v, input logic [31:0] addr, input logic [4:0] rd,
                      input rd_source_t src, input logic rwe, input logic re, input logic we,
                      input logic [2:0] f3, input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] rdata, input int lat);
        bit access, ack_now, to_now, complete, done, is_load;
        int k;
        access  = v && (re || we);
        is_load = re && !we;
        inValid = v; inAluResult = addr; inRdAddr = rd; inRdSource = src;
        inRdWriteEnable = rwe; inMemReadEnable = re; inMemWriteEnable = we;
        inLoadFunct3 = f3; inMemDataToWrite = wdata; inMemByteMask = mask;
        memReadData = rdata;
        memAck = access ? (lat == 0) : 1'($urandom_range(0, 1));
        k = 0;
        done = 0;
        while (!done) begin
            #1;
            ack_now  = access && lat >= 0 && k == lat;
            to_now   = access && !ack_now && k == TO;
            complete = v && (!access || ack_now || to_now);
            check("memReq", 32'(memReq), 32'(access));
            check("stall", 32'(stall), 32'(access && !ack_now && !to_now));
            if (access && k == 0) begin
                check("memAddr", 32'(memAddr), addr >> 2);
                check("memWriteEnable", 32'(memWriteEnable), 32'(we));
                check("memByteMask", 32'(memByteMask), 32'(we ? mask : 4'hF));
                check("memWriteData", memWriteData, wdata);
            end
            @(posedge clock);
            @(negedge clock);
            if (complete) begin
                check("wbValid", 32'(wbValid), 32'd1);
                check("wbRdAddr", 32'(wbRdAddr), 32'(rd));
                check("wbRdSource", 32'(wbRdSource), 32'(src));
                check("wbRdWriteEnable", 32'(wbRdWriteEnable), 32'(rwe && !to_now));
                check("wbAluResult", wbAluResult, addr);
                check("wbBusError", 32'(wbBusError), 32'(to_now));
                check("wbMisaligned", 32'(wbMisaligned),
                      32'(access && is_load && ref_misaligned(f3, int'(addr[1:0]))));
                if (is_load && !to_now)
                    check("wbMemData", wbMemData, ref_load(rdata, f3, int'(addr[1:0])));
                done = 1;
            end else begin
                check("bubble wbValid", 32'(wbValid), 32'd0);
                check("bubble wbRdWriteEnable", 32'(wbRdWriteEnable), 32'd0);
                if (!v) done = 1;
                k++;
                memAck = access && lat >= 0 && k == lat;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        inValid = 0; inAluResult = 0; inRdAddr = 0; inRdSource = RD_SRC_ALU;
        inRdWriteEnable = 0; inMemReadEnable = 0; inMemWriteEnable = 0;
        inLoadFunct3 = 0; inMemDataToWrite = 0; inMemByteMask = 0;
        memAck = 0; memReadData = 0;
        @(posedge clock);
        @(negedge clock);
        check("reset wbValid", 32'(wbValid), 32'd0);
        check("reset wbAluResult", wbAluResult, 32'd0);
        check("reset wbMemData", wbMemData, 32'd0);
        check("reset wbBusError", 32'(wbBusError), 32'd0);
        inValid = 1; inMemReadEnable = 1;
        #1;
        check("reset memReq", 32'(memReq), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("reset held wbValid", 32'(wbValid), 32'd0);
        inValid = 0; inMemReadEnable = 0;
        reset = 1'b0;

        // ALU op, store with zero-wait ack, LB/LBU with 3 wait cycles
        op(1, 32'h1234, 5'd5, RD_SRC_ALU, 1, 0, 0, 3'd0, 32'h0, 4'h0, 32'h0, 0);
        op(1, 32'h100, 5'd0, RD_SRC_ALU, 0, 0, 1, 3'd2, 32'hCAFEF00D, 4'hF, 32'h0, 0);
        op(1, 32'h103, 5'd7, RD_SRC_MEM, 1, 1, 0, LOAD_LB, 32'h0, 4'h0, 32'h80123456, 3);
        op(1, 32'h103, 5'd8, RD_SRC_MEM, 1, 1, 0, LOAD_LBU, 32'h0, 4'h0, 32'h80123456, 3);
        // Misaligned LH, aligned upper-half LHU, load+store where store wins
        op(1, 32'h101, 5'd9, RD_SRC_MEM, 1, 1, 0, LOAD_LH, 32'h0, 4'h0, 32'h12348765, 1);
        op(1, 32'h102, 5'd10, RD_SRC_MEM, 1, 1, 0, LOAD_LHU, 32'h0, 4'h0, 32'hBEEF0000, 0);
        op(1, 32'h204, 5'd11, RD_SRC_PC4, 1, 1, 1, LOAD_LW, 32'h00AB0000, 4'h4, 32'h0, 2);
        op(0, 32'h300, 5'd12, RD_SRC_ALU, 1, 1, 0, LOAD_LW, 32'h0, 4'h0, 32'h0, 0);
        // Never-acked load times out
        op(1, 32'h40, 5'd13, RD_SRC_MEM, 1, 1, 0, LOAD_LW, 32'h0, 4'h0, 32'h55AA55AA, -1);

        // Reset in the middle of a wait
        inValid = 1; inAluResult = 32'h80; inMemReadEnable = 1; inMemWriteEnable = 0;
        inRdWriteEnable = 1; memAck = 0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        inValid = 0;
        #1;
        check("midwait reset memReq", 32'(memReq), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post reset memReq", 32'(memReq), 32'd0);
        check("post reset stall", 32'(stall), 32'd0);
        check("post reset wbValid", 32'(wbValid), 32'd0);
        op(1, 32'h88, 5'd14, RD_SRC_MEM, 1, 1, 0, LOAD_LW, 32'h0, 4'h0, 32'h13579BDF, 1);
        op(1, 32'h8C, 5'd15, RD_SRC_MEM, 1, 1, 0, LOAD_LW, 32'h0, 4'h0, 32'h0, -1);

        // Random back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            logic [2:0] f3s[5];
            int kind, r;
            logic re, we;
            f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            kind = $urandom_range(0, 3);
            re = (kind == 1 || kind == 3);
            we = (kind == 2 || kind == 3);
            r = $urandom_range(0, 9);
            op(($urandom_range(0, 9) != 0), $urandom, 5'($urandom),
               rd_source_t'($urandom_range(0, 3)), 1'($urandom), re, we,
               f3s[$urandom_range(0, 4)], $urandom, 4'($urandom), $urandom,
               (r == 9) ? -1 : r % 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
